// File: rtl/mcu_collector_pkg.sv
// Shared types and constants for the MCU collector.
// Channel tags, valid masks, FSM states and the 8x8 block type.
package mcu_collector_pkg;

  localparam int SAMPLE_W = 9;

  localparam logic [1:0] CH_Y  = 2'd0;
  localparam logic [1:0] CH_CB = 2'd1;
  localparam logic [1:0] CH_CR = 2'd2;

  localparam logic [3:0] MASK_LUMA   = 4'b0001;
  localparam logic [3:0] MASK_CHROMA = 4'b1111;

  localparam logic [2:0] BLK_CB = 3'd4;
  localparam logic [2:0] BLK_CR = 3'd5;

  localparam logic [7:0] CNT_LAST = 8'hFF;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } collect_state_t;

  typedef logic [7:0][7:0][SAMPLE_W-1:0] block_t;

endpackage

// File: rtl/mcu_plane_buf.sv
// One 16x16 sample plane of the MCU buffer.
// Quadrant writes (single or all four) and a row/col read port.
module mcu_plane_buf #(
  parameter int W = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic                        wr_all,
  input  logic [1:0]                  wr_quad,
  input  logic [3:0][7:0][7:0][W-1:0] blk_i,
  input  logic [3:0]                  rd_row,
  input  logic [3:0]                  rd_col,
  output logic [W-1:0]                rd_data
);

  logic [15:0][15:0][W-1:0] mem_q;
  logic [15:0][15:0][W-1:0] mem_d;

  // Place blocks into their quadrants; single writes take block 0.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int q = 0; q < 4; q++) begin
        if (wr_all || (wr_quad == 2'(q))) begin
          for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
              mem_d[4'((q / 2) * 8 + r)][4'((q % 2) * 8 + c)] =
                wr_all ? blk_i[2'(q)][3'(r)][3'(c)]
                       : blk_i[0][3'(r)][3'(c)];
            end
          end
        end
      end
    end
  end

  // Read the next-state contents so a block written this cycle
  // is already visible to the output registers.
  always_comb begin
    rd_data = mem_d[rd_row][rd_col];
  end

  // Plane storage, cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/mcu_collector.sv
// Collects four luma blocks plus upsampled Cb/Cr into one MCU
// and streams it out as 256 raster-order Y/Cb/Cr pixels.
module mcu_collector
  import mcu_collector_pkg::*;
#(
  parameter int W = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             valid_in,
  input  logic [1:0]             ch_in,
  input  logic [7:0][7:0][W-1:0] block_1_in,
  input  logic [7:0][7:0][W-1:0] block_2_in,
  input  logic [7:0][7:0][W-1:0] block_3_in,
  input  logic [7:0][7:0][W-1:0] block_4_in,
  output logic                   in_ready,
  output logic                   err,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [W-1:0]           y_out,
  output logic [W-1:0]           cb_out,
  output logic [W-1:0]           cr_out,
  output logic [3:0]             pix_row,
  output logic [3:0]             pix_col,
  output logic                   pix_last
);

  collect_state_t state_q, state_d;
  logic [2:0]     blk_cnt_q, blk_cnt_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           pix_valid_q, pix_valid_d;
  logic           pix_last_q, pix_last_d;
  logic [W-1:0]   y_q, y_d;
  logic [W-1:0]   cb_q, cb_d;
  logic [W-1:0]   cr_q, cr_d;

  logic [3:0][7:0][7:0][W-1:0] blks;
  logic [1:0]   exp_ch;
  logic [3:0]   exp_mask;
  logic         xfer;
  logic         match;
  logic         y_we, cb_we, cr_we;
  logic [W-1:0] y_rd, cb_rd, cr_rd;

  assign blks = {block_4_in, block_3_in, block_2_in, block_1_in};

  // Transfer expected at the current collection step.
  always_comb begin
    exp_ch   = CH_Y;
    exp_mask = MASK_LUMA;
    unique case (1'b1)
      (blk_cnt_q == BLK_CB): begin
        exp_ch   = CH_CB;
        exp_mask = MASK_CHROMA;
      end
      (blk_cnt_q == BLK_CR): begin
        exp_ch   = CH_CR;
        exp_mask = MASK_CHROMA;
      end
      default: ;
    endcase
  end

  assign xfer  = (valid_in != 4'd0);
  assign match = (valid_in == exp_mask) && (ch_in == exp_ch);

  // Next-state: collection steps, drain counter, sticky error.
  always_comb begin
    state_d   = state_q;
    blk_cnt_d = blk_cnt_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    y_we      = 1'b0;
    cb_we     = 1'b0;
    cr_we     = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (xfer) begin
          if (match) begin
            y_we  = ~blk_cnt_q[2];
            cb_we = (blk_cnt_q == BLK_CB);
            cr_we = (blk_cnt_q == BLK_CR);
            if (blk_cnt_q == BLK_CR) begin
              blk_cnt_d = 3'd0;
              cnt_d     = 8'd0;
              state_d   = DRAIN;
            end else begin
              blk_cnt_d = blk_cnt_q + 3'd1;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (xfer) begin
          err_d = 1'b1;
        end
        if (pix_valid_q && pix_ready) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == CNT_LAST) begin
            state_d = COLLECT;
          end
        end
      end
    endcase
  end

  // Output registers track the pixel the counter will point at.
  always_comb begin
    pix_valid_d = (state_d == DRAIN);
    pix_last_d  = pix_valid_d && (cnt_d == CNT_LAST);
    y_d  = pix_valid_d ? y_rd  : y_q;
    cb_d = pix_valid_d ? cb_rd : cb_q;
    cr_d = pix_valid_d ? cr_rd : cr_q;
  end

  mcu_plane_buf #(.W(W)) u_y_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (y_we),
    .wr_all  (1'b0),
    .wr_quad (blk_cnt_q[1:0]),
    .blk_i   (blks),
    .rd_row  (cnt_d[7:4]),
    .rd_col  (cnt_d[3:0]),
    .rd_data (y_rd)
  );

  mcu_plane_buf #(.W(W)) u_cb_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cb_we),
    .wr_all  (1'b1),
    .wr_quad (2'd0),
    .blk_i   (blks),
    .rd_row  (cnt_d[7:4]),
    .rd_col  (cnt_d[3:0]),
    .rd_data (cb_rd)
  );

  mcu_plane_buf #(.W(W)) u_cr_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cr_we),
    .wr_all  (1'b1),
    .wr_quad (2'd0),
    .blk_i   (blks),
    .rd_row  (cnt_d[7:4]),
    .rd_col  (cnt_d[3:0]),
    .rd_data (cr_rd)
  );

  // FSM, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COLLECT;
      blk_cnt_q   <= 3'd0;
      cnt_q       <= 8'd0;
      err_q       <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
      y_q         <= '0;
      cb_q        <= '0;
      cr_q        <= '0;
    end else begin
      state_q     <= state_d;
      blk_cnt_q   <= blk_cnt_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      pix_valid_q <= pix_valid_d;
      pix_last_q  <= pix_last_d;
      y_q         <= y_d;
      cb_q        <= cb_d;
      cr_q        <= cr_d;
    end
  end

  assign in_ready  = (state_q == COLLECT);
  assign err       = err_q;
  assign pix_valid = pix_valid_q;
  assign pix_last  = pix_last_q;
  assign pix_row   = cnt_q[7:4];
  assign pix_col   = cnt_q[3:0];
  assign y_out     = y_q;
  assign cb_out    = cb_q;
  assign cr_out    = cr_q;

endmodule

// File: tb/tb_mcu_collector.sv
// Randomized bench for mcu_collector with a behavioural MCU model
// and a per-cycle compare process.
module tb_mcu_collector;
  import mcu_collector_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] valid_in = 4'd0;
  logic [1:0] ch_in = 2'd0;
  block_t     bk [4];
  logic       in_ready, err, pix_valid;
  logic       pix_ready = 1'b0;
  logic [8:0] y_out, cb_out, cr_out;
  logic [3:0] pix_row, pix_col;
  logic       pix_last;

  always #5 clk = ~clk;

  mcu_collector #(.W(9)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .ch_in      (ch_in),
    .block_1_in (bk[0]),
    .block_2_in (bk[1]),
    .block_3_in (bk[2]),
    .block_4_in (bk[3]),
    .in_ready   (in_ready),
    .err        (err),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .y_out      (y_out),
    .cb_out     (cb_out),
    .cr_out     (cr_out),
    .pix_row    (pix_row),
    .pix_col    (pix_col),
    .pix_last   (pix_last)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp,
               $time);
    end
  endtask

  // Behavioural model: three 256-entry planes in raster order.
  int mY [256];
  int mCb[256];
  int mCr[256];
  int m_k = 0;
  int m_p = 0;
  bit m_drain = 1'b0;
  bit m_err = 1'b0;
  bit m_hold = 1'b0;

  task automatic mreset();
    m_k = 0;
    m_p = 0;
    m_drain = 1'b0;
    m_err = 1'b0;
    m_hold = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mY[i] = 0;
      mCb[i] = 0;
      mCr[i] = 0;
    end
  endtask

  task automatic mstore(input int plane, input int quad,
                        input block_t b);
    int idx;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        idx = ((quad / 2) * 8 + r) * 16 + (quad % 2) * 8 + c;
        if (plane == 0) mY[idx] = int'(b[r][c]);
        else if (plane == 1) mCb[idx] = int'(b[r][c]);
        else mCr[idx] = int'(b[r][c]);
      end
    end
  endtask

  // Model update on each active edge (or asynchronous reset).
  initial begin
    int ech, emask;
    mreset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mreset();
      end else begin
        m_hold = m_drain && !pix_ready;
        if (!m_drain) begin
          if (valid_in != 4'd0) begin
            if (m_k < 4) begin
              ech = 0; emask = 1;
            end else if (m_k == 4) begin
              ech = 1; emask = 15;
            end else begin
              ech = 2; emask = 15;
            end
            if (int'(ch_in) == ech && int'(valid_in) == emask) begin
              if (m_k < 4) mstore(0, m_k, bk[0]);
              else for (int q = 0; q < 4; q++) mstore(m_k - 3, q, bk[q]);
              if (m_k == 5) begin
                m_k = 0;
                m_drain = 1'b1;
                m_p = 0;
              end else begin
                m_k++;
              end
            end else begin
              m_err = 1'b1;
            end
          end
        end else begin
          if (valid_in != 4'd0) m_err = 1'b1;
          if (pix_ready) begin
            if (m_p == 255) m_drain = 1'b0;
            m_p++;
          end
        end
      end
    end
  end

  // Compare DUT against model on every falling edge out of reset.
  initial begin
    int py, pcb, pcr;
    py = 0; pcb = 0; pcr = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("pix_valid", int'(pix_valid), int'(m_drain));
        chk("in_ready", int'(in_ready), int'(!m_drain));
        chk("err", int'(err), int'(m_err));
        if (m_drain) begin
          chk("y_out", int'(y_out), mY[m_p]);
          chk("cb_out", int'(cb_out), mCb[m_p]);
          chk("cr_out", int'(cr_out), mCr[m_p]);
          chk("pix_row", int'(pix_row), m_p / 16);
          chk("pix_col", int'(pix_col), m_p % 16);
          chk("pix_last", int'(pix_last), int'(m_p == 255));
          if (m_hold) begin
            chk("hold_y", int'(y_out), py);
            chk("hold_cb", int'(cb_out), pcb);
            chk("hold_cr", int'(cr_out), pcr);
          end
        end
        py = int'(y_out);
        pcb = int'(cb_out);
        pcr = int'(cr_out);
      end
    end
  end

  // pix_ready policy: 0 = driven by test, 1 = high, 2 = random.
  int rmode = 1;
  initial begin
    forever begin
      @(negedge clk);
      if (rmode == 1) pix_ready = 1'b1;
      else if (rmode == 2) pix_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic set_blk(input int k, input int v);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        bk[k][r][c] = 9'(v);
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 4; k++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          bk[k][r][c] = 9'($urandom_range(0, 511));
  endtask

  task automatic send(input logic [1:0] ch, input logic [3:0] mask,
                      input bit wait_rdy);
    int n;
    @(negedge clk);
    n = 0;
    if (wait_rdy) begin
      while (!in_ready && n < 2000) begin
        valid_in = 4'd0;
        @(negedge clk);
        n++;
      end
      if (!in_ready) chk("send_timeout", 0, 1);
    end
    ch_in = ch;
    valid_in = mask;
    @(posedge clk);
    #1;
    valid_in = 4'd0;
  endtask

  task automatic send_mcu_rand(input bit wait_rdy);
    for (int i = 0; i < 4; i++) begin
      fill_rand();
      send(CH_Y, MASK_LUMA, wait_rdy);
    end
    fill_rand();
    send(CH_CB, MASK_CHROMA, wait_rdy);
    fill_rand();
    send(CH_CR, MASK_CHROMA, wait_rdy);
  endtask

  task automatic wait_pix(input int r, input int c);
    int n;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (pix_valid && int'(pix_row) == r && int'(pix_col) == c) break;
    end
    if (n == 3000) chk("wait_pix_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!pix_valid && in_ready) break;
    end
    if (n == 3000) chk("wait_idle_timeout", 0, 1);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, hs, g;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) set_blk(k, 0);
    repeat (2) @(negedge clk);
    chk("rst_pix_valid", int'(pix_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_err", int'(err), 0);
    chk("rst_pix_last", int'(pix_last), 0);
    chk("rst_y", int'(y_out), 0);
    chk("rst_row", int'(pix_row), 0);
    chk("rst_col", int'(pix_col), 0);
    rst = 1'b0;

    // Directed MCU with constant blocks.
    rmode = 1;
    set_blk(0, 10); send(CH_Y, MASK_LUMA, 1'b1);
    set_blk(0, 20); send(CH_Y, MASK_LUMA, 1'b1);
    set_blk(0, 30); send(CH_Y, MASK_LUMA, 1'b1);
    set_blk(0, 40); send(CH_Y, MASK_LUMA, 1'b1);
    for (int k = 0; k < 4; k++) set_blk(k, 100 + k);
    send(CH_CB, MASK_CHROMA, 1'b1);
    for (int k = 0; k < 4; k++) set_blk(k, 200 + k);
    send(CH_CR, MASK_CHROMA, 1'b1);
    wait_pix(0, 0);
    chk("p00_y", int'(y_out), 10);
    chk("p00_cb", int'(cb_out), 100);
    chk("p00_cr", int'(cr_out), 200);
    wait_pix(0, 8);
    chk("p08_y", int'(y_out), 20);
    chk("p08_cb", int'(cb_out), 101);
    chk("p08_cr", int'(cr_out), 201);
    wait_pix(15, 15);
    chk("pff_y", int'(y_out), 40);
    chk("pff_cb", int'(cb_out), 103);
    chk("pff_cr", int'(cr_out), 203);
    chk("pff_last", int'(pix_last), 1);
    @(negedge clk);
    chk("after_last_ready", int'(in_ready), 1);
    chk("after_last_valid", int'(pix_valid), 0);

    // Backpressure: pix_ready high on every other drain cycle.
    rmode = 0;
    pix_ready = 1'b0;
    send_mcu_rand(1'b1);
    cyc = 0;
    hs = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (!pix_valid) break;
      pix_ready = (cyc % 2 == 0);
      if (pix_ready) hs++;
      cyc++;
    end
    chk("bp_drain_cycles", cyc, 511);
    chk("bp_handshakes", hs, 256);
    rmode = 1;
    wait_idle();

    // Protocol error: Cb transfer while expecting luma.
    chk("pre_err", int'(err), 0);
    fill_rand();
    send(CH_CB, MASK_CHROMA, 1'b1);
    @(negedge clk);
    chk("proto_err", int'(err), 1);
    chk("proto_in_ready", int'(in_ready), 1);
    rmode = 2;
    send_mcu_rand(1'b1);
    wait_idle();
    rmode = 1;

    // Input presented while draining.
    rst_pulse();
    send_mcu_rand(1'b1);
    wait_pix(1, 0);
    chk("drain_pre_err", int'(err), 0);
    fill_rand();
    send(CH_Y, MASK_LUMA, 1'b0);
    @(negedge clk);
    chk("drain_err", int'(err), 1);
    wait_idle();

    // Reset in the middle of a drain.
    send_mcu_rand(1'b1);
    wait_pix(2, 5);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", int'(pix_valid), 0);
    chk("mid_rst_ready", int'(in_ready), 1);
    chk("mid_rst_err", int'(err), 0);
    @(negedge clk);
    rst = 1'b0;
    send_mcu_rand(1'b1);
    @(negedge clk);
    chk("post_rst_valid", int'(pix_valid), 1);
    chk("post_rst_row", int'(pix_row), 0);
    chk("post_rst_col", int'(pix_col), 0);
    wait_idle();

    // Back-to-back MCUs.
    send_mcu_rand(1'b1);
    fork
      send_mcu_rand(1'b1);
      begin
        wait_pix(15, 15);
        g = 0;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          g++;
          if (g == 1) begin
            chk("b2b_gap_valid", int'(pix_valid), 0);
            chk("b2b_gap_ready", int'(in_ready), 1);
          end
          if (pix_valid) break;
        end
        chk("b2b_restart_cycles", g, 7);
      end
    join
    wait_idle();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
